// File: rtl/poisson_spike_encoder_pkg.sv
// Shared neuron-bank definitions: default geometry, scan FSM encoding and the
// saturating rate constant used by the spike encoder.
package poisson_spike_encoder_pkg;

  localparam int NUM_NEURONS_DEF = 16;
  localparam int ID_W_DEF        = 4;
  localparam int RATE_W_DEF      = 16;

  // Held at 32 bits so any RATE_W up to the RNG word width can truncate it.
  localparam logic [31:0] RATE_ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } enc_state_e;

endpackage

// File: rtl/poisson_spike_encoder_rate_regfile.sv
// Per-neuron firing-rate storage: synchronous write, asynchronous read, and an
// asynchronous clear on reset.
module poisson_spike_encoder_rate_regfile
  import poisson_spike_encoder_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int ID_W        = ID_W_DEF,
  parameter int RATE_W      = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ID_W-1:0]   waddr_i,
  input  logic [RATE_W-1:0] wdata_i,
  input  logic [ID_W-1:0]   raddr_i,
  output logic [RATE_W-1:0] rdata_o
);

  logic [RATE_W-1:0] mem_q [NUM_NEURONS];
  logic              waddr_ok;
  logic              raddr_ok;

  // Addresses beyond the populated neurons are silently ignored.
  assign waddr_ok = 32'(waddr_i) < NUM_NEURONS;
  assign raddr_ok = 32'(raddr_i) < NUM_NEURONS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && waddr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = raddr_ok ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/poisson_spike_encoder.sv
// Poisson spike encoder: each timestep scans every neuron, compares one fresh
// RNG word against its rate and streams the hits out as neuron ids.
//
//   state | meaning
//   IDLE  | waiting for timestep_start
//   DRAW  | compare rate[idx] with the current random word, advance RNG
//   EMIT  | present spike_id until the consumer accepts it
//   DONE  | one-cycle completion pulse, then back to IDLE
module poisson_spike_encoder
  import poisson_spike_encoder_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int ID_W        = ID_W_DEF,
  parameter int RATE_W      = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rate_we,
  input  logic [ID_W-1:0]   rate_addr,
  input  logic [RATE_W-1:0] rate_wdata,
  input  logic              timestep_start,
  input  logic [31:0]       random_in,
  output logic              rng_enable,
  output logic              spike_valid,
  input  logic              spike_ready,
  output logic [ID_W-1:0]   spike_id,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [ID_W-1:0]   LAST_IDX = ID_W'(NUM_NEURONS - 1);
  localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(RATE_ALL_ONES);

  enc_state_e        state_q, state_d;
  logic [ID_W-1:0]   idx_q, idx_d;
  logic [ID_W-1:0]   spike_id_q, spike_id_d;
  logic              overrun_q, overrun_d;
  logic [RATE_W-1:0] rate_cur;
  logic              hit;
  logic              last_idx;
  logic              unused_rnd_hi;

  poisson_spike_encoder_rate_regfile #(
    .NUM_NEURONS (NUM_NEURONS),
    .ID_W        (ID_W),
    .RATE_W      (RATE_W)
  ) u_rate_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (rate_we),
    .waddr_i (rate_addr),
    .wdata_i (rate_wdata),
    .raddr_i (idx_q),
    .rdata_o (rate_cur)
  );

  // The all-ones rate is forced to fire so that probability 1.0 is reachable.
  assign hit           = (rate_cur == RATE_MAX) || (random_in[RATE_W-1:0] < rate_cur);
  assign last_idx      = (idx_q == LAST_IDX);
  assign unused_rnd_hi = ^random_in[31:RATE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      spike_id_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      spike_id_q <= spike_id_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    spike_id_d = spike_id_q;
    // Any start outside IDLE, including the DONE->IDLE cycle, is dropped.
    overrun_d  = timestep_start && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (timestep_start) begin
          state_d = ST_DRAW;
          idx_d   = '0;
        end
      end
      ST_DRAW: begin
        if (hit) begin
          state_d    = ST_EMIT;
          spike_id_d = idx_q;
        end else if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_EMIT: begin
        if (spike_ready) begin
          if (last_idx) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAW;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rng_enable  = 1'b0;
    spike_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_DRAW: begin
        rng_enable = 1'b1;
        busy       = 1'b1;
      end
      ST_EMIT: begin
        spike_valid = 1'b1;
        busy        = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign spike_id = spike_id_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_poisson_spike_encoder.sv
// Self-checking bench for poisson_spike_encoder: a rate model predicts the spike
// ids of each scan into a queue that is drained as the DUT transfers events.
module tb_poisson_spike_encoder;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rate_we = 1'b0;
  logic [3:0]  rate_addr = '0;
  logic [15:0] rate_wdata = '0;
  logic        timestep_start = 1'b0;
  logic [31:0] random_in = '0;
  logic        spike_ready = 1'b1;
  logic        rng_enable;
  logic        spike_valid;
  logic [3:0]  spike_id;
  logic        busy;
  logic        done;
  logic        overrun;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_rate [N];
  int          exp_q [$];

  poisson_spike_encoder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rate_we        (rate_we),
    .rate_addr      (rate_addr),
    .rate_wdata     (rate_wdata),
    .timestep_start (timestep_start),
    .random_in      (random_in),
    .rng_enable     (rng_enable),
    .spike_valid    (spike_valid),
    .spike_ready    (spike_ready),
    .spike_id       (spike_id),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic write_rate(input int a, input logic [15:0] v);
    @(posedge clk); #1;
    rate_we    = 1'b1;
    rate_addr  = a[3:0];
    rate_wdata = v;
    model_rate[a] = v;
    @(posedge clk); #1;
    rate_we = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) model_rate[i] = '0;
  endtask

  // One timestep scan. stall = ready-low cycles on the first spike,
  // extra_start = cycle offset of a second (overrun) start pulse, 0 for none.
  task automatic run_scan(input string tag, input int stall, input int extra_start);
    int          hits;
    int          t0;
    int          lat;
    int          rngs;
    int          ovr;
    int          ovr_rel;
    int          stall_left;
    int          exp_lat;
    logic [15:0] r;
    hits = 0; lat = -1; rngs = 0; ovr = 0; ovr_rel = -1;
    r = random_in[15:0];
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (model_rate[i] == 16'hFFFF || r < model_rate[i]) begin
        exp_q.push_back(i);
        hits++;
      end
    end
    exp_lat    = 17 + hits + ((hits > 0) ? stall : 0);
    stall_left = stall;
    @(posedge clk); #1;
    timestep_start = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      timestep_start = (k == extra_start);
      if (spike_valid && stall_left > 0) begin
        spike_ready = 1'b0;
        stall_left--;
      end else begin
        spike_ready = 1'b1;
      end
      @(negedge clk);
      if (rng_enable) rngs++;
      if (overrun) begin
        ovr++;
        ovr_rel = cyc - t0;
      end
      if (spike_valid && spike_ready) begin
        if (exp_q.size() == 0) check({tag, "_extra_spike"}, {28'h0, spike_id}, 32'hEE);
        else check({tag, "_spike_id"}, {28'h0, spike_id}, exp_q.pop_front());
      end
      if (spike_valid && !spike_ready) begin
        check({tag, "_stall_id"}, {28'h0, spike_id}, (exp_q.size() > 0) ? exp_q[0] : 32'hEE);
        check({tag, "_stall_rng"}, {31'h0, rng_enable}, 32'h0);
      end
      if (lat >= 0) begin
        check({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
        check({tag, "_done_width"}, {31'h0, done}, 32'h0);
        break;
      end
      if (done) lat = cyc - t0;
    end
    timestep_start = 1'b0;
    spike_ready    = 1'b1;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rng_cycles"}, rngs, 16);
    check({tag, "_missing"}, exp_q.size(), 0);
    check({tag, "_overruns"}, ovr, (extra_start > 0) ? 1 : 0);
    if (extra_start > 0) check({tag, "_overrun_at"}, ovr_rel, extra_start + 1);
  endtask

  initial begin
    clear_model();
    #12;
    check("reset_outputs", {23'h0, rng_enable, spike_valid, spike_id, busy, done, overrun}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    random_in = 32'h0000_0000;
    run_scan("defaults", 0, 0);

    write_rate(3, 16'h8000);
    write_rate(9, 16'hFFFF);
    random_in = 32'h0000_7FFF;
    run_scan("hitmiss", 0, 0);

    run_scan("overrun", 0, 3);

    write_rate(3, 16'h0000);
    write_rate(9, 16'h0000);
    write_rate(5, 16'h8000);
    random_in = 32'h0000_8000;
    run_scan("bound_eq", 0, 0);

    write_rate(5, 16'hFFFF);
    random_in = 32'hFFFF_FFFF;
    run_scan("bound_max", 0, 0);

    write_rate(5, 16'h0000);
    write_rate(0, 16'hFFFF);
    run_scan("backpressure", 4, 0);

    write_rate(0, 16'h0000);
    random_in = 32'h0000_0000;
    run_scan("overrun_done", 0, 17);

    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 2))
          0:       write_rate(i, 16'h0000);
          1:       write_rate(i, 16'hFFFF);
          default: write_rate(i, 16'($urandom));
        endcase
      end
      random_in = $urandom;
      run_scan("random", round, 0);
    end

    clear_model();
    for (int i = 0; i < N; i++) write_rate(i, 16'h0000);
    write_rate(2, 16'hFFFF);
    random_in = 32'h0000_0000;
    @(posedge clk); #1;
    timestep_start = 1'b1;
    @(posedge clk); #1;
    timestep_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (spike_valid) break;
    end
    check("emit_reached", {31'h0, spike_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("midscan_reset_outputs", {23'h0, rng_enable, spike_valid, spike_id, busy, done, overrun}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_scan("post_reset", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poisson_spike_encoder.md
Name: poisson_spike_encoder

Overview:
- Downstream consumer of the neuron-bank LFSR random number generator.
- Converts per-neuron firing-rate registers into stochastic input spikes, once per simulation timestep.
- Scans all neurons sequentially. For each neuron it draws one random word and compares it to that neuron's rate. Each hit is emitted as a spike event (neuron id) over a valid/ready handshake toward the neuron bank input queue.

Parameters:
- NUM_NEURONS, 16, number of rate entries scanned per timestep (>=2).
- ID_W, 4, width of neuron index; must satisfy 2^ID_W >= NUM_NEURONS.
- RATE_W, 16, width of rate value and of the compared random slice.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rate_we  input  1  rate register write strobe.
- rate_addr  input  ID_W  rate register index.
- rate_wdata  input  RATE_W  rate value; spike probability = rate/2^RATE_W.
- timestep_start  input  1  single-cycle pulse starting a scan.
- random_in  input  32  current RNG output word.
- rng_enable  output  1  advance request to RNG.
- spike_valid  output  1  spike event valid.
- spike_ready  input  1  consumer accepts event.
- spike_id  output  ID_W  index of spiking neuron.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse at scan completion.
- overrun  output  1  one-cycle pulse when timestep_start arrives while busy.

Behaviour:
- Reset (async, rst_n=0):
  - All rate registers cleared to 0; state IDLE; idx=0.
  - All outputs 0: rng_enable, spike_valid, spike_id, busy, done, overrun.
- Rate writes:
  - Accepted in any state. The written value is visible to the compare from the next cycle onward.
  - rate_addr >= NUM_NEURONS is ignored.
- FSM states are IDLE, DRAW, EMIT and DONE.
- IDLE:
  - On timestep_start, go to DRAW with idx=0 and busy=1 from the next cycle.
- DRAW (one neuron per cycle):
  - rng_enable=1 for this cycle only, so the RNG holds a fresh word on the next cycle.
  - hit = (rate[idx] == all-ones) OR (random_in[RATE_W-1:0] < rate[idx]).
  - Rate 0 never fires. Rate all-ones always fires.
  - On hit: go to EMIT with spike_id=idx registered.
  - On miss: if idx==NUM_NEURONS-1, go to DONE; else idx+1 and stay in DRAW.
- EMIT:
  - spike_valid=1 and rng_enable=0.
  - spike_id is held stable until spike_ready is sampled high (transfer on the valid&&ready cycle).
  - On transfer: if idx is last, go to DONE; else idx+1 and go to DRAW.
  - spike_valid is never withdrawn without a transfer.
- DONE:
  - done=1 for exactly one cycle, busy drops in the same cycle, next state IDLE.
- Latency:
  - A scan with no hits asserts done exactly NUM_NEURONS+1 cycles after the timestep_start edge.
  - Each hit adds 1 + (cycles spike_ready is low).
- Concurrent events:
  - timestep_start in DRAW, EMIT or DONE is dropped, with overrun=1 in the following cycle. The scan continues unaffected.
  - timestep_start in the same cycle as the DONE->IDLE transition is also an overrun, not a restart.
- Rate write to the current idx during DRAW: the compare uses the pre-write value.
- Reset mid-scan: immediate return to IDLE and any pending spike is lost. The rate array is also cleared.
- Ordering: spike ids are emitted in strictly ascending order within a timestep, each id at most once.

Decomposition:
- Shared neuron-bank package holds:
  - the FSM state encoding (IDLE/DRAW/EMIT/DONE, 2 bits);
  - default NUM_NEURONS, ID_W and RATE_W constants;
  - the all-ones rate constant.
- Natural sub-module: rate_regfile, the NUM_NEURONS x RATE_W register array. It has a synchronous write port and an async-read port indexed by idx, with async-reset clear.
- The FSM and compare stay in the top module. The RNG is instantiated by the parent, not inside this block.

Test Plan:
- Reset defaults: all rates 0, tie random_in=32'h0000_0000, pulse timestep_start. Required: zero spike_valid, rng_enable high for 16 consecutive cycles, done 17 cycles after start, busy low afterwards.
- Hit/miss compare: rate[3]=16'h8000, rate[9]=16'hFFFF, others 0, random_in=32'h0000_7FFF constant, spike_ready=1. Required: spikes id 3 then id 9 only; done at start+19.
- Boundary: rate[5]=16'h8000 with random_in low half=16'h8000 gives no spike; rate[5]=16'hFFFF with random_in=32'hFFFF_FFFF gives a spike on id 5.
- Backpressure: rate[0]=16'hFFFF, spike_ready held low 4 cycles. Required: spike_valid stays 1 and spike_id stays 0 through the stall; rng_enable stays 0; one transfer; scan resumes at id 1.
- Overrun: second timestep_start 3 cycles after the first. Required: overrun pulse one cycle later, a single done, and spike sequence identical to the single-start run.
- Async reset mid-EMIT: rst_n low while spike_valid=1. Required: all outputs 0 immediately; after release, a new timestep_start with no rates written yields no spikes.
